// File: rtl/mat_pkg.sv
// mat_pkg: matrix-bus definitions (element/matrix types, packing helper, serializer states)
package mat_pkg;
    localparam int ELEM_W = 16;
    localparam int DIM    = 4;
    localparam int MAT_W  = ELEM_W * DIM * DIM;
    typedef logic signed [ELEM_W-1:0] elem_t;
    typedef logic [MAT_W-1:0] mat_t;
    typedef enum logic {IDLE, STREAM} state_t;
    // element (r,c) sits at row-major slot DIM*r+c, slot 0 in the MSBs
    function automatic elem_t elem_at(input mat_t m, input logic [1:0] r, input logic [1:0] c);
        int idx;
        idx = DIM * int'(r) + int'(c);
        return elem_t'(m[MAT_W-1-ELEM_W*idx -: ELEM_W]);
    endfunction
endpackage

// File: rtl/mat_serializer.sv
// mat_serializer: accepts a packed 4x4 matrix and streams its elements one per cycle
// ports: clk, rst (sync, active high); in_valid/in_ready/in_mat/in_trans matrix input;
//        out_valid/out_ready/out_data/out_row/out_col/out_last element output; busy = STREAM
module mat_serializer
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MAT_W-1:0]  in_mat,
    input  logic              in_trans,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic [1:0]        out_row,
    output logic [1:0]        out_col,
    output logic              out_last,
    output logic              busy
);
    state_t     state;
    mat_t       mat_q;
    logic       trans_q;
    logic [3:0] k;
    logic [3:0] kn;
    logic       take;
    logic       adv;
    elem_t      nxt;
    assign kn       = k + 4'd1;
    // in STREAM a new matrix is only taken in the cycle the last element leaves
    assign in_ready = !rst && (state == IDLE || (out_ready && out_last));
    assign take     = in_valid && in_ready;
    assign adv      = out_valid && out_ready;
    assign busy     = state == STREAM;
    // transposed read swaps the stored row/column roles
    assign nxt      = trans_q ? elem_at(mat_q, kn[1:0], kn[3:2]) : elem_at(mat_q, kn[3:2], kn[1:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mat_q     <= '0;
            trans_q   <= 1'b0;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else if (take) begin
            // element (0,0) is the same for both orders
            state     <= STREAM;
            mat_q     <= in_mat;
            trans_q   <= in_trans;
            k         <= '0;
            out_valid <= 1'b1;
            out_data  <= elem_at(in_mat, 2'd0, 2'd0);
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                k         <= '0;
            end else begin
                k        <= kn;
                out_data <= nxt;
                out_row  <= kn[3:2];
                out_col  <= kn[1:0];
                out_last <= kn == 4'hF;
            end
        end
    end
endmodule

// File: tb/tb_mat_serializer.sv
// tb_mat_serializer: table-driven and randomized checks of mat_serializer against a matrix model
module tb_mat_serializer;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_mat;
    logic         in_trans;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [1:0]   out_row;
    logic [1:0]   out_col;
    logic         out_last;
    logic         busy;

    int checks = 0;
    int failures = 0;
    logic [15:0] cur_m[16];
    logic [15:0] got[16];

    typedef struct {
        string       name;
        int          kind;
        bit          trans;
        int          rdy_mode;
        bit          noise;
        logic [15:0] exp_k0;
        logic [15:0] exp_k1;
        logic [15:0] exp_k15;
    } vec_t;

    mat_serializer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mat(in_mat),
        .in_trans(in_trans), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] pack(input logic [15:0] m[16]);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[255-16*i -: 16] = m[i];
        return v;
    endfunction

    task automatic fill(input int kind);
        for (int i = 0; i < 16; i++)
            cur_m[i] = kind == 0 ? 16'(16 * (i / 4) + i % 4) :
                       kind == 1 ? (16'hF000 | 16'(i)) : 16'($urandom);
        if (kind == 1) begin
            cur_m[0]  = 16'h8000;
            cur_m[15] = 16'hFFFF;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // load cur_m, then consume 16 elements under the given ready pattern
    task automatic run_stream(input string nm, input bit trans, input int rdy_mode, input bit noise);
        logic [15:0] exp_q[16];
        logic [20:0] prev;
        int n;
        int cyc;
        bit stalled;
        for (int k = 0; k < 16; k++)
            exp_q[k] = trans ? cur_m[4 * (k % 4) + k / 4] : cur_m[4 * (k / 4) + k % 4];
        in_mat = pack(cur_m);
        in_trans = trans;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1 chk({nm, " in_ready idle"}, 32'(in_ready), 1);
        next_cycle();
        in_valid = 1'b0;
        if (noise) begin
            in_mat = ~pack(cur_m);
            in_trans = ~trans;
        end
        n = 0;
        cyc = 0;
        stalled = 0;
        prev = '0;
        while (n < 16 && cyc < 200) begin
            in_valid = noise && n >= 2 && n <= 10;
            out_ready = rdy_mode == 0 ? 1'b1 :
                        rdy_mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
            #1;
            chk({nm, " out_valid"}, 32'(out_valid), 1);
            chk({nm, " busy"}, 32'(busy), 1);
            chk({nm, " in_ready"}, 32'(in_ready), 32'(out_ready && n == 15));
            if (stalled) chk({nm, " stall stable"}, 32'({out_data, out_row, out_col, out_last}), 32'(prev));
            if (out_ready) begin
                chk({nm, " data"}, 32'(out_data), 32'(exp_q[n]));
                chk({nm, " row/col"}, 32'({out_row, out_col}), 32'(n));
                chk({nm, " last"}, 32'(out_last), 32'(n == 15));
                got[n] = out_data;
                n++;
                stalled = 0;
            end else begin
                stalled = 1;
                prev = {out_data, out_row, out_col, out_last};
            end
            next_cycle();
            cyc++;
        end
        if (n < 16) chk({nm, " handshake count (timeout)"}, 32'(n), 16);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk({nm, " idle out_valid"}, 32'(out_valid), 0);
        chk({nm, " idle busy"}, 32'(busy), 0);
        chk({nm, " idle in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{"basic",     0, 1'b0, 0, 1'b0, 16'h0000, 16'h0001, 16'h0033};
        vecs[1] = '{"transpose", 0, 1'b1, 0, 1'b0, 16'h0000, 16'h0010, 16'h0033};
        vecs[2] = '{"signed_bp", 1, 1'b0, 1, 1'b0, 16'h8000, 16'hF001, 16'hFFFF};
        vecs[3] = '{"ignore_in", 0, 1'b0, 0, 1'b1, 16'h0000, 16'h0001, 16'h0033};
        vecs[4] = '{"signed_tr", 1, 1'b1, 2, 1'b0, 16'h8000, 16'hF004, 16'hFFFF};

        rst = 1'b1;
        in_valid = 1'b0;
        in_mat = '0;
        in_trans = 1'b0;
        out_ready = 1'b0;
        repeat (2) next_cycle();
        #1;
        chk("reset in_ready", 32'(in_ready), 0);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset outputs", 32'({out_data, out_row, out_col, out_last}), 0);
        rst = 1'b0;
        #1 chk("post-reset in_ready", 32'(in_ready), 1);

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].kind);
            run_stream(vecs[v].name, vecs[v].trans, vecs[v].rdy_mode, vecs[v].noise);
            chk({vecs[v].name, " k0"}, 32'(got[0]), 32'(vecs[v].exp_k0));
            chk({vecs[v].name, " k1"}, 32'(got[1]), 32'(vecs[v].exp_k1));
            chk({vecs[v].name, " k15"}, 32'(got[15]), 32'(vecs[v].exp_k15));
        end

        // back-to-back: A = all 1, B = all 2, in_valid held across A's last handshake
        for (int i = 0; i < 16; i++) cur_m[i] = 16'h0001;
        in_mat = pack(cur_m);
        in_trans = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        next_cycle();
        for (int i = 0; i < 16; i++) cur_m[i] = 16'h0002;
        in_mat = pack(cur_m);
        for (int n = 0; n < 32; n++) begin
            #1;
            chk("b2b out_valid", 32'(out_valid), 1);
            chk("b2b data", 32'(out_data), n < 16 ? 1 : 2);
            chk("b2b row/col", 32'({out_row, out_col}), 32'(n % 16));
            chk("b2b last", 32'(out_last), 32'(n % 16 == 15));
            chk("b2b in_ready", 32'(in_ready), 32'(n % 16 == 15));
            next_cycle();
            if (n == 15) in_valid = 1'b0;
        end
        #1 chk("b2b end out_valid", 32'(out_valid), 0);

        // reset mid-stream after 5 handshakes
        fill(2);
        in_mat = pack(cur_m);
        in_valid = 1'b1;
        out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        repeat (5) next_cycle();
        #1 chk("midrst k5 data", 32'(out_data), 32'(cur_m[5]));
        rst = 1'b1;
        #1 chk("midrst in_ready", 32'(in_ready), 0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 0);
        chk("midrst busy", 32'(busy), 0);
        next_cycle();
        #1 chk("midrst no stale", 32'(out_valid), 0);
        fill(2);
        run_stream("after_rst", 1'b0, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            fill(2);
            run_stream("random", 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
